// File: rtl/press_classifier.sv
// Classifies a debounced button level into short/long/auto-repeat single-cycle pulses.
// Optional macro PRESS_REPEAT_EN enables the auto-repeat counter in the HELD state.
module press_classifier #(
    parameter int CLK_FREQ  = 100000000,
    parameter int LONG_MS   = 1000,
    parameter int REPEAT_MS = 250
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_level,
    output logic short_press,
    output logic long_press,
    output logic repeat_press,
    output logic held
);

    localparam int LONG_CYCLES   = (CLK_FREQ / 1000) * LONG_MS;
    localparam int REPEAT_CYCLES = (CLK_FREQ / 1000) * REPEAT_MS;
`ifdef PRESS_REPEAT_EN
    localparam int MAX_CYCLES = (LONG_CYCLES > REPEAT_CYCLES) ? LONG_CYCLES : REPEAT_CYCLES;
`else
    localparam int MAX_CYCLES = LONG_CYCLES;
`endif
    localparam int CNT_W = $clog2(MAX_CYCLES);
    localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYCLES - 1);

    generate
        if (LONG_CYCLES < 2 || REPEAT_CYCLES < 2) begin : g_bad_params
            $error("press_classifier: LONG_CYCLES and REPEAT_CYCLES must both be >= 2");
        end
    endgenerate

    typedef enum logic [1:0] {LOCKOUT, IDLE, PRESSED, HELD} state_t;

    state_t           state_reg, state_next;
    logic [CNT_W-1:0] hold_cnt_reg, hold_cnt_next;
    logic             short_reg, short_next;
    logic             long_reg, long_next;
    logic             held_reg, held_next;

`ifdef PRESS_REPEAT_EN
    localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_CYCLES - 1);
    logic             repeat_reg, repeat_next;
`endif

    always_comb begin
        state_next    = state_reg;
        hold_cnt_next = hold_cnt_reg;
        short_next    = 1'b0;
        long_next     = 1'b0;
`ifdef PRESS_REPEAT_EN
        repeat_next   = 1'b0;
`endif
        case (state_reg)
            // A level already high when we leave reset must be released first.
            LOCKOUT: begin
                hold_cnt_next = '0;
                if (!btn_level) state_next = IDLE;
            end
            IDLE: begin
                if (btn_level) begin
                    state_next    = PRESSED;
                    hold_cnt_next = CNT_W'(1);
                end
            end
            PRESSED: begin
                if (!btn_level) begin
                    short_next    = 1'b1;
                    state_next    = IDLE;
                    hold_cnt_next = '0;
                end else if (hold_cnt_reg == LONG_LAST) begin
                    long_next     = 1'b1;
                    state_next    = HELD;
                    hold_cnt_next = '0;
                end else begin
                    hold_cnt_next = hold_cnt_reg + CNT_W'(1);
                end
            end
            HELD: begin
                if (!btn_level) begin
                    state_next    = IDLE;
                    hold_cnt_next = '0;
                end else begin
`ifdef PRESS_REPEAT_EN
                    if (hold_cnt_reg == REPEAT_LAST) begin
                        repeat_next   = 1'b1;
                        hold_cnt_next = '0;
                    end else begin
                        hold_cnt_next = hold_cnt_reg + CNT_W'(1);
                    end
`else
                    hold_cnt_next = '0;
`endif
                end
            end
        endcase
        held_next = (state_next == PRESSED) || (state_next == HELD);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg    <= LOCKOUT;
            hold_cnt_reg <= '0;
            short_reg    <= 1'b0;
            long_reg     <= 1'b0;
            held_reg     <= 1'b0;
`ifdef PRESS_REPEAT_EN
            repeat_reg   <= 1'b0;
`endif
        end else begin
            state_reg    <= state_next;
            hold_cnt_reg <= hold_cnt_next;
            short_reg    <= short_next;
            long_reg     <= long_next;
            held_reg     <= held_next;
`ifdef PRESS_REPEAT_EN
            repeat_reg   <= repeat_next;
`endif
        end
    end

    assign short_press = short_reg;
    assign long_press  = long_reg;
    assign held        = held_reg;
`ifdef PRESS_REPEAT_EN
    assign repeat_press = repeat_reg;
`else
    assign repeat_press = 1'b0;
`endif

endmodule

// File: tb/tb_press_classifier.sv
// Directed bench for press_classifier with 1 cycle per ms (long = 10 cycles, repeat = 4 cycles).
module tb_press_classifier;

    localparam int LONG_C = 10;
    localparam int REP_C  = 4;
`ifdef PRESS_REPEAT_EN
    localparam int REP_20 = 2;
    localparam int REP_30 = 5;
`else
    localparam int REP_20 = 0;
    localparam int REP_30 = 0;
`endif

    logic clk = 1'b0;
    logic reset;
    logic btn_level;
    logic short_press, long_press, repeat_press, held;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int short_t[$];
    int long_t[$];
    int rep_t[$];
    int n_held  = 0;
    int n_multi = 0;

    press_classifier #(
        .CLK_FREQ (1000),
        .LONG_MS  (10),
        .REPEAT_MS(4)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .btn_level   (btn_level),
        .short_press (short_press),
        .long_press  (long_press),
        .repeat_press(repeat_press),
        .held        (held)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Outputs are observed on the falling edge; cyc then names the edge that produced them.
    always @(negedge clk) begin
        if (short_press)  short_t.push_back(cyc);
        if (long_press)   long_t.push_back(cyc);
        if (repeat_press) rep_t.push_back(cyc);
        if (held)         n_held = n_held + 1;
        if (int'(short_press) + int'(long_press) + int'(repeat_press) > 1) n_multi = n_multi + 1;
    end

    task automatic check(input string tag, input int got, input int exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Hold the button for n sampled edges, release, and check the classified result.
    task automatic run_press(input string tag, input int n, input int exp_short,
                             input int exp_long, input int exp_rep);
        int s0, l0, r0, h0, k;
        s0 = short_t.size();
        l0 = long_t.size();
        r0 = rep_t.size();
        h0 = n_held;
        k  = cyc + 1;
        btn_level = 1'b1;
        repeat (n) @(negedge clk);
        btn_level = 1'b0;
        repeat (3) @(negedge clk);
        check({tag, ".short_cnt"}, short_t.size() - s0, exp_short);
        check({tag, ".long_cnt"},  long_t.size() - l0,  exp_long);
        check({tag, ".rep_cnt"},   rep_t.size() - r0,   exp_rep);
        check({tag, ".held_cyc"},  n_held - h0,         n);
        if (exp_short > 0 && short_t.size() > s0)
            check({tag, ".short_at"}, short_t[s0] - k, n);
        if (exp_long > 0 && long_t.size() > l0)
            check({tag, ".long_at"}, long_t[l0] - k, LONG_C - 1);
        if (exp_rep > 0 && rep_t.size() > r0)
            check({tag, ".rep1_at"}, rep_t[r0] - k, LONG_C - 1 + REP_C);
        if (exp_rep > 1 && rep_t.size() > r0 + 1)
            check({tag, ".rep2_at"}, rep_t[r0 + 1] - k, LONG_C - 1 + 2 * REP_C);
        $display("press %s: hold=%0d short=%0d long=%0d rep=%0d held_cycles=%0d", tag, n,
                 short_t.size() - s0, long_t.size() - l0, rep_t.size() - r0, n_held - h0);
    endtask

    initial begin
        int s0, l0, r0, h0;
        reset = 1'b1;
        btn_level = 1'b0;
        repeat (3) @(negedge clk);
        check("rst.short", int'(short_press), 0);
        check("rst.long",  int'(long_press),  0);
        check("rst.rep",   int'(repeat_press), 0);
        check("rst.held",  int'(held), 0);
        $display("reset: short=%0b long=%0b rep=%0b held=%0b", short_press, long_press, repeat_press, held);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        run_press("short5", 5, 1, 0, 0);
        run_press("long20", 20, 0, 1, REP_20);
        run_press("edge9", LONG_C - 1, 1, 0, 0);
        run_press("edge10", LONG_C, 0, 1, 0);
        run_press("pulse1", 1, 1, 0, 0);
        run_press("long30", 30, 0, 1, REP_30);

        // Back-to-back: 2-cycle press, 1-cycle gap, 3-cycle press.
        s0 = short_t.size();
        l0 = long_t.size();
        btn_level = 1'b1;
        repeat (2) @(negedge clk);
        btn_level = 1'b0;
        @(negedge clk);
        btn_level = 1'b1;
        repeat (3) @(negedge clk);
        btn_level = 1'b0;
        repeat (3) @(negedge clk);
        check("b2b.short_cnt", short_t.size() - s0, 2);
        check("b2b.long_cnt",  long_t.size() - l0,  0);
        $display("press b2b: short=%0d long=%0d", short_t.size() - s0, long_t.size() - l0);

        // Button held across reset: locked out until released.
        s0 = short_t.size();
        l0 = long_t.size();
        r0 = rep_t.size();
        h0 = n_held;
        reset = 1'b1;
        btn_level = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (30) @(negedge clk);
        btn_level = 1'b0;
        repeat (3) @(negedge clk);
        check("lock.short_cnt", short_t.size() - s0, 0);
        check("lock.long_cnt",  long_t.size() - l0,  0);
        check("lock.rep_cnt",   rep_t.size() - r0,   0);
        check("lock.held_cyc",  n_held - h0,         0);
        $display("press lockout: short=%0d long=%0d held_cycles=%0d",
                 short_t.size() - s0, long_t.size() - l0, n_held - h0);
        run_press("after_lock3", 3, 1, 0, 0);

        // Reset pulse during a press at its 7th cycle.
        s0 = short_t.size();
        l0 = long_t.size();
        btn_level = 1'b1;
        repeat (6) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("midrst.held",  int'(held), 0);
        check("midrst.short", int'(short_press), 0);
        check("midrst.long",  int'(long_press), 0);
        reset = 1'b0;
        repeat (10) @(negedge clk);
        btn_level = 1'b0;
        repeat (3) @(negedge clk);
        check("midrst.short_cnt", short_t.size() - s0, 0);
        check("midrst.long_cnt",  long_t.size() - l0,  0);
        $display("press midreset: short=%0d long=%0d", short_t.size() - s0, long_t.size() - l0);
        run_press("after_rst2", 2, 1, 0, 0);

        check("exclusive", n_multi, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
